// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the PC, issues single-outstanding requests to
// instruction memory and drives the registered instr / pc_plus_4 / interrupt
// slot that decode reads. Redirects come back from decode on branch_sel, and
// interrupts are taken by injecting INT_INSTR into the slot.
//
// Memory handshake: imem_req is a one-cycle strobe and imem_addr is
// meaningful only in that cycle. Memory answers exactly once, one or more
// cycles later, with a one-cycle imem_valid carrying imem_rdata. There is no
// ready signal: a new request is issued only after the previous answer has
// been taken (or a reset has abandoned it), so at most one is in flight.
// Decode consumes the slot on a cycle where valid=1 and stall=0.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] INT_INSTR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_sel,
   input  logic [31:0] branch_pc,
   input  logic        returni,
   input  logic        int_req,
   output logic        int_ack,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc_plus_4,
   output logic        interrupt,
   output logic        valid,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt, pc_inc;
   logic [31:0] hold_buf, hold_buf_nxt;
   logic        drop, drop_nxt;
   logic        int_pending, int_pending_nxt;
   logic        in_isr, in_isr_nxt;
   logic [31:0] instr_nxt, pc_plus_4_nxt;
   logic        valid_nxt, interrupt_nxt;
   logic        inject, deliver;
   logic [31:0] deliver_word;

   // pc+4 wraps modulo 2^32; the fetch address is the raw PC, alignment is decode's job.
   assign pc_inc    = pc + 32'd4;
   assign imem_addr = pc;
   assign fsm_state = state;

   // State register plus PC, hold buffer, slot and interrupt bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         hold_buf    <= NOP_INSTR;
         drop        <= 1'b0;
         int_pending <= 1'b0;
         in_isr      <= 1'b0;
         instr       <= NOP_INSTR;
         pc_plus_4   <= 32'd0;
         valid       <= 1'b0;
         interrupt   <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         hold_buf    <= hold_buf_nxt;
         drop        <= drop_nxt;
         int_pending <= int_pending_nxt;
         in_isr      <= in_isr_nxt;
         instr       <= instr_nxt;
         pc_plus_4   <= pc_plus_4_nxt;
         valid       <= valid_nxt;
         interrupt   <= interrupt_nxt;
      end
   end

   // Next-state, slot update and request/ack strobes; redirect overrides all but reset.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      hold_buf_nxt    = hold_buf;
      drop_nxt        = drop;
      int_pending_nxt = int_pending;
      in_isr_nxt      = in_isr;
      instr_nxt       = instr;
      pc_plus_4_nxt   = pc_plus_4;
      valid_nxt       = valid;
      interrupt_nxt   = interrupt;
      imem_req        = 1'b0;
      int_ack         = 1'b0;
      deliver         = 1'b0;
      deliver_word    = hold_buf;
      inject          = (state == FETCH) && int_pending && !in_isr && !stall && !branch_sel;

      case (state)
         FETCH: begin
            if (!branch_sel) begin
               if (inject) begin
                  // Return PC is the next unexecuted instruction, i.e. the current PC.
                  instr_nxt     = INT_INSTR;
                  pc_plus_4_nxt = pc;
                  valid_nxt     = 1'b1;
                  interrupt_nxt = 1'b1;
                  int_ack       = 1'b1;
               end else begin
                  imem_req  = 1'b1;
                  state_nxt = WAIT;
                  if (!stall) begin
                     valid_nxt = 1'b0;
                     instr_nxt = NOP_INSTR;
                  end
               end
            end
         end
         WAIT: begin
            if (branch_sel) begin
               // A response still in flight belongs to the old path: mark it for discard.
               if (imem_valid) begin
                  state_nxt = FETCH;
                  drop_nxt  = 1'b0;
               end else begin
                  drop_nxt = 1'b1;
               end
            end else if (imem_valid) begin
               if (drop) begin
                  drop_nxt  = 1'b0;
                  state_nxt = FETCH;
                  if (!stall) begin
                     valid_nxt = 1'b0;
                     instr_nxt = NOP_INSTR;
                  end
               end else if (stall) begin
                  hold_buf_nxt = imem_rdata;
                  state_nxt    = HOLD;
               end else begin
                  deliver      = 1'b1;
                  deliver_word = imem_rdata;
               end
            end else if (!stall) begin
               valid_nxt = 1'b0;
               instr_nxt = NOP_INSTR;
            end
         end
         HOLD: begin
            if (branch_sel) begin
               state_nxt = FETCH;
            end else if (!stall) begin
               deliver = 1'b1;
            end
         end
         default: state_nxt = FETCH;
      endcase

      if (deliver) begin
         instr_nxt     = deliver_word;
         pc_plus_4_nxt = pc_inc;
         valid_nxt     = 1'b1;
         interrupt_nxt = 1'b0;
         pc_nxt        = pc_inc;
         state_nxt     = FETCH;
      end

      if (branch_sel) begin
         pc_nxt        = branch_pc;
         valid_nxt     = 1'b0;
         instr_nxt     = NOP_INSTR;
         interrupt_nxt = 1'b0;
      end

      // A new request wins over the clear from an injection in the same cycle.
      if (int_req) begin
         int_pending_nxt = 1'b1;
      end else if (inject) begin
         int_pending_nxt = 1'b0;
      end

      if (inject) begin
         in_isr_nxt = 1'b1;
      end else if (returni) begin
         in_isr_nxt = 1'b0;
      end

      if (rst) begin
         imem_req = 1'b0;
         int_ack  = 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch. Inputs are driven on the falling edge and outputs
// sampled 1ns later. A reference model tracks, in program-order terms, the
// address decode should consume next and the interrupt pending/in-ISR flags;
// a small memory responder answers each request after a chosen latency.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] INT_INSTR = 32'hC0DE_0073;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branch_sel = 1'b0;
   logic [31:0] branch_pc = 32'd0;
   logic        returni = 1'b0;
   logic        int_req = 1'b0;
   logic        int_ack;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] instr;
   logic [31:0] pc_plus_4;
   logic        interrupt;
   logic        valid;
   logic [1:0]  fsm_state;

   instr_fetch #(
      .RESET_PC (RESET_PC),
      .INT_INSTR(INT_INSTR),
      .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .branch_sel(branch_sel),
      .branch_pc (branch_pc),
      .returni   (returni),
      .int_req   (int_req),
      .int_ack   (int_ack),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_valid(imem_valid),
      .imem_rdata(imem_rdata),
      .instr     (instr),
      .pc_plus_4 (pc_plus_4),
      .interrupt (interrupt),
      .valid     (valid),
      .fsm_state (fsm_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Scoreboard state
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc = RESET_PC;
   logic        m_pending = 1'b0;
   logic        m_in_isr = 1'b0;
   logic        ack_prev = 1'b0;
   logic        dut_busy = 1'b0;
   int          ack_count = 0;
   int          n_consumed = 0;

   // Memory responder state
   int          mem_cnt = 0;
   logic [31:0] mem_addr_q = 32'd0;
   int          lat_min = 1;
   int          lat_max = 1;
   logic        spur_en = 1'b0;

   // Per-cycle snapshot of DUT outputs
   logic        s_req, s_ack, s_valid, s_int;
   logic [31:0] s_addr, s_instr, s_pp4;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   // One clock cycle: memory answers, outputs are sampled and checked
   // against the program-order model, then time advances to the next negedge.
   task automatic cycle();
      logic        consumed;
      logic [31:0] want_addr;
      if (mem_cnt == 1) begin
         imem_valid = 1'b1;
         imem_rdata = mem_word(mem_addr_q);
         mem_cnt    = 0;
         dut_busy   = 1'b0;
      end else begin
         if (mem_cnt > 1) mem_cnt--;
         imem_valid = (mem_cnt == 0) && spur_en && ($urandom_range(0, 7) == 0);
         imem_rdata = $urandom;
      end
      #1;
      s_req = imem_req; s_addr = imem_addr; s_ack = int_ack;
      s_valid = valid; s_instr = instr; s_pp4 = pc_plus_4; s_int = interrupt;
      consumed = 1'b0;
      if (rst) begin
         n_checks++;
         if (s_req !== 1'b0) begin
            n_fail++; $display("FAIL req_in_reset got=%b exp=0", s_req);
         end
         n_checks++;
         if (s_ack !== 1'b0) begin
            n_fail++; $display("FAIL ack_in_reset got=%b exp=0", s_ack);
         end
         exp_pc = RESET_PC; m_pending = 1'b0; m_in_isr = 1'b0;
         ack_prev = 1'b0; dut_busy = 1'b0;
      end else begin
         if (s_valid === 1'b0) begin
            n_checks++;
            if (s_instr !== NOP_INSTR) begin
               n_fail++; $display("FAIL nop_when_invalid got=%h exp=%h", s_instr, NOP_INSTR);
            end
         end
         if (ack_prev) begin
            n_checks++;
            if ({s_valid, s_int} !== 2'b11) begin
               n_fail++; $display("FAIL inject_flags got=%b%b exp=11", s_valid, s_int);
            end
            n_checks++;
            if (s_instr !== INT_INSTR) begin
               n_fail++; $display("FAIL inject_instr got=%h exp=%h", s_instr, INT_INSTR);
            end
            n_checks++;
            if (s_pp4 !== exp_pc) begin
               n_fail++; $display("FAIL inject_ret_pc got=%h exp=%h", s_pp4, exp_pc);
            end
         end
         if (s_valid === 1'b1 && !stall && !branch_sel) begin
            consumed = 1'b1;
            n_consumed++;
            if (s_int === 1'b1) begin
               n_checks++;
               if (s_instr !== INT_INSTR || s_pp4 !== exp_pc) begin
                  n_fail++;
                  $display("FAIL consume_int got=%h/%h exp=%h/%h", s_instr, s_pp4, INT_INSTR, exp_pc);
               end
            end else begin
               n_checks++;
               if (s_instr !== mem_word(exp_pc)) begin
                  n_fail++; $display("FAIL consume_instr got=%h exp=%h", s_instr, mem_word(exp_pc));
               end
               n_checks++;
               if (s_pp4 !== exp_pc + 32'd4) begin
                  n_fail++; $display("FAIL consume_pp4 got=%h exp=%h", s_pp4, exp_pc + 32'd4);
               end
               exp_pc = exp_pc + 32'd4;
            end
         end
         if (s_ack === 1'b1) begin
            ack_count++;
            n_checks++;
            if ((m_pending && !m_in_isr && !stall && !branch_sel) !== 1'b1) begin
               n_fail++;
               $display("FAIL ack_allowed got=1 exp=0 (pending=%b in_isr=%b)", m_pending, m_in_isr);
            end
            n_checks++;
            if (s_req !== 1'b0) begin
               n_fail++; $display("FAIL req_with_ack got=%b exp=0", s_req);
            end
         end
         if (branch_sel) begin
            n_checks++;
            if (s_req !== 1'b0) begin
               n_fail++; $display("FAIL req_on_branch got=%b exp=0", s_req);
            end
         end
         if (s_req === 1'b1) begin
            n_checks++;
            if (dut_busy !== 1'b0) begin
               n_fail++; $display("FAIL single_outstanding got=busy exp=idle");
            end
            want_addr = exp_pc + ((s_valid && !s_int && !consumed) ? 32'd4 : 32'd0);
            n_checks++;
            if (s_addr !== want_addr) begin
               n_fail++; $display("FAIL fetch_addr got=%h exp=%h", s_addr, want_addr);
            end
         end
         if (branch_sel) exp_pc = branch_pc;
         if (int_req) m_pending = 1'b1;
         else if (s_ack === 1'b1) m_pending = 1'b0;
         if (s_ack === 1'b1) m_in_isr = 1'b1;
         else if (returni) m_in_isr = 1'b0;
         ack_prev = (s_ack === 1'b1);
      end
      if (s_req === 1'b1) begin
         mem_addr_q = s_addr;
         mem_cnt    = $urandom_range(lat_min, lat_max);
         dut_busy   = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Driver tasks
   task automatic drive_idle();
      stall = 1'b0; branch_sel = 1'b0; branch_pc = 32'd0;
      int_req = 1'b0; returni = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      cycle();
      cycle();
      mem_cnt = 0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      lat_min = 1; lat_max = 1; spur_en = 1'b0;
      do_reset();
      n_checks++;
      if (s_valid !== 1'b0 || s_int !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags got=%b%b exp=00", s_valid, s_int);
      end
      n_checks++;
      if (s_instr !== NOP_INSTR) begin
         n_fail++; $display("FAIL reset_instr got=%h exp=%h", s_instr, NOP_INSTR);
      end
      n_checks++;
      if (s_pp4 !== 32'd0) begin
         n_fail++; $display("FAIL reset_pp4 got=%h exp=0", s_pp4);
      end
   endtask

   task automatic test_sequential();
      logic exp_req;
      logic [31:0] want;
      lat_min = 1; lat_max = 1; spur_en = 1'b0;
      do_reset();
      exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
      for (int i = 0; i < 8; i++) begin
         cycle();
         exp_req = (i % 2 == 0);
         n_checks++;
         if (s_req !== exp_req) begin
            n_fail++; $display("FAIL seq_req[%0d] got=%b exp=%b", i, s_req, exp_req);
         end
         if (exp_req && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++;
            if (s_addr !== want) begin
               n_fail++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, s_addr, want);
            end
         end
         if (exp_req && i >= 2) begin
            n_checks++;
            if (s_valid !== 1'b1 || s_pp4 !== 32'(i * 2) || s_instr !== mem_word(32'(i * 2 - 4))) begin
               n_fail++;
               $display("FAIL seq_slot[%0d] got=%b/%h/%h exp=1/%h/%h", i, s_valid, s_pp4, s_instr,
                        32'(i * 2), mem_word(32'(i * 2 - 4)));
            end
         end
      end
   endtask

   task automatic test_stall();
      lat_min = 1; lat_max = 1; spur_en = 1'b0;
      do_reset();
      cycle();
      cycle();
      stall = 1'b1;
      cycle();
      n_checks++;
      if (s_valid !== 1'b1 || s_pp4 !== 32'h4 || s_instr !== mem_word(32'h0)) begin
         n_fail++; $display("FAIL stall_first_slot got=%b/%h exp=1/00000004", s_valid, s_pp4);
      end
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if (s_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_req[%0d] got=%b exp=0", i, s_req);
         end
         n_checks++;
         if (s_valid !== 1'b1 || s_pp4 !== 32'h4 || s_instr !== mem_word(32'h0)) begin
            n_fail++;
            $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/00000004/%h", i, s_valid, s_pp4, s_instr,
                     mem_word(32'h0));
         end
      end
      stall = 1'b0;
      cycle();
      n_checks++;
      if (s_req !== 1'b0) begin
         n_fail++; $display("FAIL stall_release_req got=%b exp=0", s_req);
      end
      cycle();
      n_checks++;
      if (s_valid !== 1'b1 || s_pp4 !== 32'h8 || s_instr !== mem_word(32'h4)) begin
         n_fail++; $display("FAIL stall_deliver got=%b/%h exp=1/00000008", s_valid, s_pp4);
      end
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h8) begin
         n_fail++; $display("FAIL stall_next_addr got=%b/%h exp=1/00000008", s_req, s_addr);
      end
      cycle();
      n_checks++;
      if (s_valid !== 1'b0) begin
         n_fail++; $display("FAIL stall_no_dup got=%b exp=0", s_valid);
      end
   endtask

   task automatic test_branch();
      logic found;
      lat_min = 3; lat_max = 3; spur_en = 1'b0;
      do_reset();
      cycle();
      branch_sel = 1'b1; branch_pc = 32'h100;
      cycle();
      branch_sel = 1'b0; branch_pc = 32'h0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         cycle();
         if (s_req === 1'b1) begin
            found = 1'b1;
            n_checks++;
            if (s_addr !== 32'h100) begin
               n_fail++; $display("FAIL branch_target got=%h exp=00000100", s_addr);
            end
         end else begin
            n_checks++;
            if (s_valid !== 1'b0) begin
               n_fail++; $display("FAIL branch_flush got=%b exp=0", s_valid);
            end
         end
      end
      n_checks++;
      if (found !== 1'b1) begin
         n_fail++; $display("FAIL branch_refetch got=none exp=request");
      end
      for (int i = 0; i < 6; i++) cycle();
   endtask

   task automatic test_interrupt();
      logic found;
      int   a0;
      lat_min = 1; lat_max = 1; spur_en = 1'b0;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (s_req === 1'b1 && s_addr === 32'h1C) found = 1'b1;
      end
      n_checks++;
      if (found !== 1'b1) begin
         n_fail++; $display("FAIL int_reach_1c got=none exp=request");
      end
      int_req = 1'b1;
      cycle();
      int_req = 1'b0;
      cycle();
      n_checks++;
      if (s_ack !== 1'b1 || s_req !== 1'b0) begin
         n_fail++; $display("FAIL int_ack_pulse got=%b/%b exp=1/0", s_ack, s_req);
      end
      cycle();
      n_checks++;
      if (s_instr !== INT_INSTR || s_int !== 1'b1 || s_pp4 !== 32'h20 || s_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL int_slot got=%h/%b/%h/%b exp=%h/1/00000020/0", s_instr, s_int, s_pp4, s_ack,
                  INT_INSTR);
      end
      a0 = ack_count;
      int_req = 1'b1;
      cycle();
      int_req = 1'b0;
      for (int i = 0; i < 12; i++) cycle();
      n_checks++;
      if (ack_count !== a0) begin
         n_fail++; $display("FAIL int_held_off got=%0d exp=%0d", ack_count, a0);
      end
      returni = 1'b1;
      cycle();
      returni = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      n_checks++;
      if (ack_count !== a0 + 1) begin
         n_fail++; $display("FAIL int_after_returni got=%0d exp=%0d", ack_count, a0 + 1);
      end
   endtask

   task automatic test_reset_mid();
      logic found;
      lat_min = 2; lat_max = 2; spur_en = 1'b0;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (s_req === 1'b1 && s_addr !== RESET_PC) found = 1'b1;
      end
      n_checks++;
      if (found !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_setup got=none exp=request");
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
         n_fail++; $display("FAIL rstmid_refetch got=%b/%h exp=1/%h", s_req, s_addr, RESET_PC);
      end
      n_checks++;
      if (s_valid !== 1'b0 || s_int !== 1'b0 || s_ack !== 1'b0 || s_pp4 !== 32'd0 || s_instr !== NOP_INSTR) begin
         n_fail++;
         $display("FAIL rstmid_outputs got=%b/%b/%b/%h/%h exp=0/0/0/00000000/%h", s_valid, s_int, s_ack,
                  s_pp4, s_instr, NOP_INSTR);
      end
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         cycle();
         if (s_valid === 1'b1) begin
            found = 1'b1;
            n_checks++;
            if (s_pp4 !== RESET_PC + 32'd4 || s_instr !== mem_word(RESET_PC)) begin
               n_fail++; $display("FAIL rstmid_first got=%h/%h exp=%h/%h", s_pp4, s_instr,
                                  RESET_PC + 32'd4, mem_word(RESET_PC));
            end
         end
      end
      n_checks++;
      if (found !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_deliver got=none exp=valid");
      end
   endtask

   task automatic test_wrap();
      lat_min = 1; lat_max = 1; spur_en = 1'b0;
      do_reset();
      branch_sel = 1'b1; branch_pc = 32'hFFFF_FFFC;
      cycle();
      branch_sel = 1'b0; branch_pc = 32'h0;
      cycle();
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
         n_fail++; $display("FAIL wrap_fetch got=%b/%h exp=1/fffffffc", s_req, s_addr);
      end
      cycle();
      cycle();
      n_checks++;
      if (s_valid !== 1'b1 || s_pp4 !== 32'd0 || s_instr !== mem_word(32'hFFFF_FFFC)) begin
         n_fail++; $display("FAIL wrap_pp4 got=%b/%h exp=1/00000000", s_valid, s_pp4);
      end
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== 32'd0) begin
         n_fail++; $display("FAIL wrap_next_addr got=%b/%h exp=1/00000000", s_req, s_addr);
      end
   endtask

   task automatic test_random();
      int c0;
      lat_min = 1; lat_max = 3; spur_en = 1'b1;
      do_reset();
      c0 = n_consumed;
      for (int i = 0; i < 1500; i++) begin
         stall      = ($urandom_range(0, 3) == 0);
         branch_sel = ($urandom_range(0, 24) == 0);
         branch_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                  : $urandom;
         int_req    = ($urandom_range(0, 29) == 0);
         returni    = m_in_isr && ($urandom_range(0, 15) == 0);
         cycle();
      end
      drive_idle();
      spur_en = 1'b0;
      n_checks++;
      if (n_consumed - c0 < 100) begin
         n_fail++; $display("FAIL random_progress got=%0d exp>=100", n_consumed - c0);
      end
   endtask

   // Test sequence and final report
   initial begin
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_interrupt();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage and producer side of the fetch/decode pipeline boundary. Owns the PC and issues single-outstanding requests to instruction memory. Drives the registered instr / pc_plus_4 / interrupt slot that decode consumes, and accepts redirects (branch_pc, branch_sel) back from decode. Interrupts are delivered by injecting a fixed instruction word into the slot; decode then executes that word like any other instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
INT_INSTR, 32'h0000_0000, instruction word injected on interrupt entry (team encodes a call to the ISR vector).
NOP_INSTR, 32'h0000_0000, word driven on instr when the slot is invalid or flushed.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  1  hazard hold; the output slot and PC must not advance
branch_sel  in  1  redirect request from decode
branch_pc  in  32  redirect target
returni  in  1  return-from-interrupt retired; re-enables interrupt injection
int_req  in  1  external interrupt request, level or pulse
int_ack  out  1  one-cycle pulse when INT_INSTR is injected
imem_req  out  1  one-cycle fetch request strobe
imem_addr  out  32  fetch address; valid while imem_req=1
imem_valid  in  1  read data valid
imem_rdata  in  32  read data
instr  out  32  registered instruction to decode
pc_plus_4  out  32  registered fetch PC+4; return PC when interrupt=1
interrupt  out  1  slot holds an injected interrupt instruction
valid  out  1  slot holds a real instruction

Behaviour:
- Reset (rst=1 at a clock edge): pc=RESET_PC; state=FETCH; valid=0; instr=NOP_INSTR; pc_plus_4=0; interrupt=0; imem_req=0; int_ack=0; drop=0; int_pending=0; in_isr=0. Reset overrides all other inputs, including mid-request. A response that arrives after reset is ignored, because state is FETCH and not WAIT.
- States: FETCH, WAIT, HOLD. At most one request is outstanding. Memory latency is at least 1 cycle.
- FETCH: if no injection this cycle: imem_req=1, imem_addr=pc, go to WAIT.
- WAIT, on imem_valid:
  - drop=1: discard the data, clear drop, go to FETCH.
  - stall=1: latch the data into the hold buffer, go to HOLD.
  - otherwise: instr<=rdata, pc_plus_4<=pc+4, valid<=1, interrupt<=0, pc<=pc+4, go to FETCH.
- HOLD: when stall=0, deliver the buffered word exactly as in WAIT delivery, then go to FETCH.
- Slot: while stall=1 and there is no branch, instr / pc_plus_4 / valid / interrupt hold their values. When FETCH issues a request or is waiting, with stall=0 and no delivery, valid<=0 and instr<=NOP_INSTR.
- Branch (branch_sel=1) has the highest priority below rst and takes effect even if stall=1:
  - pc<=branch_pc; slot flushed (valid<=0, instr<=NOP_INSTR, interrupt<=0).
  - In WAIT without imem_valid: drop<=1 and stay in WAIT.
  - In WAIT with imem_valid in the same cycle: discard the data, go to FETCH.
  - In HOLD: discard the buffer, go to FETCH.
  - In FETCH: no request that cycle; the next cycle fetches branch_pc.
- Interrupt:
  - int_req=1 sets int_pending.
  - Injection happens in FETCH when int_pending=1, in_isr=0, stall=0 and branch_sel=0:
    - instr<=INT_INSTR, pc_plus_4<=pc (address of the next unexecuted instruction), interrupt<=1, valid<=1.
    - int_ack=1 for that cycle; in_isr<=1; int_pending<=0.
    - No imem_req that cycle; pc unchanged; stay in FETCH.
  - returni=1 clears in_isr. With int_req and returni in the same cycle, pending is set and in_isr is cleared.
  - Requests made while in_isr=1 stay pending.
- Arithmetic: pc+4 is modulo 2^32 and wraps from 32'hFFFF_FFFC to 0 with no flag. imem_addr low bits are passed through unaligned; decode owns alignment.
- An imem_valid in FETCH or HOLD is ignored.

Test Plan:
- Reset with memory latency 1: sequential fetch from 0 -> imem_addr 0,4,8 on every other cycle; slot shows instr words with pc_plus_4 = 4,8,12 and valid=1 on each.
- stall=1 for 3 cycles while a response arrives -> slot unchanged and no new imem_req; on release the buffered word is delivered once and pc advances by 4 only.
- branch_sel=1, branch_pc=32'h100, with a request outstanding, latency 3 -> stale response discarded, valid=0 for the flush, next imem_addr=32'h100.
- int_req pulse at pc=32'h20 -> the next FETCH cycle shows instr=INT_INSTR, interrupt=1, pc_plus_4=32'h20, and int_ack pulses once. A second int_req is held off until returni, then injected.
- rst asserted during WAIT, with the response arriving the next cycle -> response ignored; imem_addr=RESET_PC follows and all outputs are at their reset values.
- pc=32'hFFFF_FFFC -> delivered pc_plus_4=0 and the next fetch address is 0.
